fir_sym_mc: RTL and testbench

Multi-channel, symmetric (linear-phase) folded FIR filter with a time-multiplexed pre-adder/MAC datapath.
- Each channel owns a private N_TAPS-deep delay line.
- All channels share one half-length, runtime-writable coefficient bank.
- Samples arrive on a valid/ready handshake; each accepted sample is processed in N_TAPS/2 MAC cycles.
- The result is rounded, saturated and presented with a one-cycle valid pulse and a channel tag.
- Successor to the single-channel fixed-ROM FIR: adds channels, coefficient loading, handshake, and round/saturate output.

---
 rtl/fir_sym_mc.sv | 167 ++++++++++++++++
 tb/tb_fir_sym_mc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric (linear-phase) FIR with one shared, time-multiplexed
// pre-adder/MAC, a runtime-writable half-length coefficient bank and round/saturate output.
module fir_sym_mc #(
    parameter int WIDTH_DATA  = 8,
    parameter int WIDTH_COEF  = 8,
    parameter int N_TAPS      = 16,
    parameter int LOG2_N_TAPS = 4,
    parameter int N_CH        = 2,
    parameter int LOG2_N_CH   = 1,
    parameter int WIDTH_OUT   = 16,
    parameter int SHIFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [WIDTH_DATA-1:0]  din,
    input  logic [LOG2_N_CH-1:0]          din_ch,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          coef_we,
    input  logic [LOG2_N_TAPS-2:0]        coef_addr,
    input  logic signed [WIDTH_COEF-1:0]  coef_din,
    output logic signed [WIDTH_OUT-1:0]   dout,
    output logic [LOG2_N_CH-1:0]          dout_ch,
    output logic                          dout_valid
);
    localparam int H      = N_TAPS / 2;
    localparam int KW     = LOG2_N_TAPS - 1;
    localparam int PRE_W  = WIDTH_DATA + 1;
    localparam int PROD_W = PRE_W + WIDTH_COEF;
    localparam int ACC_W  = PROD_W + LOG2_N_TAPS;
    localparam logic [LOG2_N_CH:0] NCH = (LOG2_N_CH + 1)'(N_CH);
    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W + 2 - WIDTH_OUT){1'b0}}, {(WIDTH_OUT - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                        state_q, state_d;
    logic [KW-1:0]                 k_q, k_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [LOG2_N_CH-1:0]          ch_q, ch_d;
    logic signed [WIDTH_OUT-1:0]   dout_q, dout_d;
    logic [LOG2_N_CH-1:0]          dout_ch_q, dout_ch_d;
    logic                          dout_valid_q, dout_valid_d;
    logic signed [WIDTH_DATA-1:0]  line_q [N_CH][N_TAPS];
    logic signed [WIDTH_COEF-1:0]  coef_q [H];

    logic                          accept, coef_wr;
    logic [LOG2_N_TAPS-1:0]        idx_lo, idx_hi;
    logic signed [WIDTH_DATA-1:0]  x_lo, x_hi;
    logic signed [PRE_W-1:0]       pre;
    logic signed [PROD_W-1:0]      pre_ext, coef_ext, prod;
    logic signed [ACC_W-1:0]       term;

    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = {a[ACC_W-1], a};
        t = t + RND;
        return t >>> SHIFT;
    endfunction

    function automatic logic signed [WIDTH_OUT-1:0] saturate(input logic signed [ACC_W:0] v);
        if (v > MAXV)
            return MAXV[WIDTH_OUT-1:0];
        else if (v < MINV)
            return MINV[WIDTH_OUT-1:0];
        else
            return v[WIDTH_OUT-1:0];
    endfunction

    assign din_ready = rst && (state_q == IDLE);
    assign accept    = (state_q == IDLE) && din_valid && ({1'b0, din_ch} < NCH);
    assign coef_wr   = (state_q == IDLE) && coef_we;

    // Tap k pairs with tap N_TAPS-1-k, which is the bitwise complement of k.
    always_comb begin
        idx_lo   = {1'b0, k_q};
        idx_hi   = ~idx_lo;
        x_lo     = line_q[ch_q][idx_lo];
        x_hi     = line_q[ch_q][idx_hi];
        pre      = {x_lo[WIDTH_DATA-1], x_lo} + {x_hi[WIDTH_DATA-1], x_hi};
        pre_ext  = {{WIDTH_COEF{pre[PRE_W-1]}}, pre};
        coef_ext = {{PRE_W{coef_q[k_q][WIDTH_COEF-1]}}, coef_q[k_q]};
        prod     = pre_ext * coef_ext;
        term     = {{LOG2_N_TAPS{prod[PROD_W-1]}}, prod};
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        acc_d        = acc_q;
        ch_d         = ch_q;
        dout_d       = dout_q;
        dout_ch_d    = dout_ch_q;
        dout_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d    = din_ch;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + term;
                k_d   = k_q + KW'(1);
                if (&k_q)
                    state_d = OUT;
            end
            OUT: begin
                dout_d       = saturate(round_shift(acc_q));
                dout_ch_d    = ch_q;
                dout_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            acc_q        <= '0;
            ch_q         <= '0;
            dout_q       <= '0;
            dout_ch_q    <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            acc_q        <= acc_d;
            ch_q         <= ch_d;
            dout_q       <= dout_d;
            dout_ch_q    <= dout_ch_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    // Reset also clears storage so an aborted sample leaves no residue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < N_CH; c++)
                for (int i = 0; i < N_TAPS; i++)
                    line_q[c][i] <= '0;
            for (int k = 0; k < H; k++)
                coef_q[k] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (accept && din_ch == LOG2_N_CH'(c)) begin
                    line_q[c][0] <= din;
                    for (int i = 1; i < N_TAPS; i++)
                        line_q[c][i] <= line_q[c][i-1];
                end
            end
            if (coef_wr)
                coef_q[coef_addr] <= coef_din;
        end
    end

    assign dout       = dout_q;
    assign dout_ch    = dout_ch_q;
    assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_fir_sym_mc.sv
// Scoreboard bench for fir_sym_mc: three instances (3-channel, saturating SHIFT=7,
// rounding SHIFT=1) driven with directed vectors and checked against hand-computed results.
module tb_fir_sym_mc;
    typedef struct {
        int val;
        int ch;
        int cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] din;
    logic [1:0]        din_ch;
    logic [2:0]        coef_addr;
    logic signed [7:0] coef_din;
    logic [2:0]        vld, we, rdy, dv;
    logic signed [15:0] dout_a, dout_c;
    logic signed [7:0]  dout_b;
    logic [1:0]         dch_a;
    logic               dch_b, dch_c;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t qa[$], qb[$], qc[$];

    int imp   [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};
    int b_pos [16] = '{126, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
    int b_neg [16] = '{127, 127, 127, 127, 127, 127, 127, -8, -128, -128, -128, -128, -128, -128, -128, -128};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_sym_mc #(.N_CH(3), .LOG2_N_CH(2)) u_a (
        .clk(clk), .rst(rst), .din(din), .din_ch(din_ch), .din_valid(vld[0]), .din_ready(rdy[0]),
        .coef_we(we[0]), .coef_addr(coef_addr), .coef_din(coef_din),
        .dout(dout_a), .dout_ch(dch_a), .dout_valid(dv[0]));

    fir_sym_mc #(.WIDTH_OUT(8), .SHIFT(7)) u_b (
        .clk(clk), .rst(rst), .din(din), .din_ch(din_ch[0]), .din_valid(vld[1]), .din_ready(rdy[1]),
        .coef_we(we[1]), .coef_addr(coef_addr), .coef_din(coef_din),
        .dout(dout_b), .dout_ch(dch_b), .dout_valid(dv[1]));

    fir_sym_mc #(.SHIFT(1)) u_c (
        .clk(clk), .rst(rst), .din(din), .din_ch(din_ch[0]), .din_valid(vld[2]), .din_ready(rdy[2]),
        .coef_we(we[2]), .coef_addr(coef_addr), .coef_din(coef_din),
        .dout(dout_c), .dout_ch(dch_c), .dout_valid(dv[2]));

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    // Output appears 10 negedges after the negedge at which the offer is seen ready.
    task automatic push(input int d, input int v, input int ch);
        exp_t e;
        e.val = v;
        e.ch  = ch;
        e.cyc = cyc + 10;
        case (d)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic mon(input int d, input int v, input int ch);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (d)
            0:       if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
            1:       if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
            default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output dut%0d: got dout %0d ch %0d, required no strobe (cycle %0d)",
                     d, v, ch, cyc);
        end else begin
            chk($sformatf("dout_dut%0d", d), v, e.val);
            chk($sformatf("dout_ch_dut%0d", d), ch, e.ch);
            chk($sformatf("latency_dut%0d", d), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (dv[0]) mon(0, int'(dout_a), int'(dch_a));
        if (dv[1]) mon(1, int'(dout_b), int'(dch_b));
        if (dv[2]) mon(2, int'(dout_c), int'(dch_c));
    end

    task automatic load(input int d, input int k, input int v);
        @(negedge clk);
        coef_addr = 3'(k);
        coef_din  = 8'(v);
        we[d]     = 1'b1;
        @(posedge clk);
        #1;
        we[d] = 1'b0;
    endtask

    task automatic send(input int d, input int ch, input int val, input bit expect_out, input int ev,
                        input bit wr = 1'b0, input int wv = 0);
        @(negedge clk);
        din    = 8'(val);
        din_ch = 2'(ch);
        vld[d] = 1'b1;
        if (wr) begin
            coef_addr = 3'd0;
            coef_din  = 8'(wv);
            we[d]     = 1'b1;
        end
        for (int t = 0; t < 40 && !rdy[d]; t++) @(negedge clk);
        if (!rdy[d]) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: din_ready 0, required 1 within 40 cycles", d);
        end else if (expect_out) begin
            push(d, ev, ch);
        end
        @(posedge clk);
        #1;
        vld[d] = 1'b0;
        we[d]  = 1'b0;
    endtask

    task automatic drain(input int d);
        for (int t = 0; t < 60 && qsize(d) > 0; t++) @(negedge clk);
        chk($sformatf("drain_dut%0d", d), qsize(d), 0);
    endtask

    task automatic impulse_ch0();
        for (int i = 0; i < 16; i++) send(0, 0, (i == 0) ? 1 : 0, 1'b1, imp[i]);
        drain(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int last, n_acc, n_low;
        rst = 1'b0; vld = '0; we = '0; din = '0; din_ch = '0; coef_addr = '0; coef_din = '0;
        repeat (3) @(negedge clk);
        chk("dout_reset", int'(dout_a), 0);
        chk("dout_ch_reset", int'(dch_a), 0);
        chk("dout_valid_reset", int'(dv), 0);
        chk("ready_in_reset", int'(rdy), 0);
        rst = 1'b1;
        #1;
        chk("ready_after_release", int'(rdy), 7);

        for (int k = 0; k < 8; k++) load(0, k, k + 1);
        impulse_ch0();

        // Interleaved channels: ch1 impulse of 5, ch0 zeros (flushes its old impulse).
        for (int i = 0; i < 16; i++) begin
            send(0, 1, (i == 0) ? 5 : 0, 1'b1, 5 * imp[i]);
            send(0, 0, 0, 1'b1, 0);
        end
        drain(0);

        // Coefficient write attempted while busy must not land.
        send(0, 2, 1, 1'b1, 1);
        @(negedge clk);
        coef_addr = 3'd0; coef_din = 8'sd99; we[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ready_in_mac", int'(rdy[0]), 0);
            @(negedge clk);
        end
        we[0] = 1'b0;
        send(0, 2, 1, 1'b1, 3);
        drain(0);

        // Out-of-range channel is dropped; block stays idle.
        @(negedge clk);
        din = 8'sd100; din_ch = 2'd3; vld[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ready_oor", int'(rdy[0]), 1);
            @(negedge clk);
        end
        vld[0] = 1'b0;
        send(0, 2, 0, 1'b1, 5);
        drain(0);

        // Continuous offer: accepts every 10 cycles.
        @(negedge clk);
        din = '0; din_ch = 2'd0; vld[0] = 1'b1;
        last = -1; n_acc = 0; n_low = 0;
        for (int i = 0; i < 35; i++) begin
            if (rdy[0]) begin
                push(0, 0, 0);
                if (last >= 0) chk("accept_spacing", cyc - last, 10);
                last = cyc;
                n_acc++;
            end else begin
                n_low++;
            end
            @(negedge clk);
        end
        vld[0] = 1'b0;
        chk("accept_count", n_acc, 4);
        chk("ready_low_cycles", n_low, 31);
        drain(0);

        // Saturation, SHIFT=7, WIDTH_OUT=8.
        for (int k = 0; k < 8; k++) load(1, k, 127);
        for (int i = 0; i < 16; i++) send(1, 0, 127, 1'b1, b_pos[i]);
        for (int i = 0; i < 16; i++) send(1, 0, -128, 1'b1, b_neg[i]);
        drain(1);

        // Rounding, SHIFT=1, with the coefficient written in the accept cycle.
        send(2, 0, 3, 1'b1, 2, 1'b1, 1);
        drain(2);

        // Reset at k=3 of a MAC run aborts it.
        send(0, 0, 7, 1'b0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk("no_valid_after_abort", int'(dv[0]), 0);
            if (i == 1) begin
                chk("ready_mid_reset", int'(rdy[0]), 0);
                chk("dout_after_abort", int'(dout_a), 0);
            end
            if (i == 2) rst = 1'b1;
            @(negedge clk);
        end
        for (int k = 0; k < 8; k++) load(0, k, k + 1);
        impulse_ch0();

        send(2, 0, -3, 1'b1, -1, 1'b1, 1);
        drain(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
